// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the binary-to-BCD display path
package bcd_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DIGITS = 3;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD = 4'd3;
endpackage

// File: rtl/bcd_adj3.sv
// bcd_adj3: double-dabble nibble correction, add 3 when the digit is 5 or more
module bcd_adj3
  import bcd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  assign nib_o = (nib_i >= ADJ_THRESH) ? nib_i + ADJ_ADD : nib_i;
endmodule

// File: rtl/bcd_display_prep.sv
// bcd_display_prep: sequential double-dabble converter, one input bit per clock
module bcd_display_prep
  import bcd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                  Clock,
  input  logic                  Reset_b,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);
  localparam int CW = $clog2(WIDTH);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  state_t state_q, state_d;
  logic [SW-1:0] sr_q, sr_d, shifted;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bcd_q, bcd_d, adj;
  logic last;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (.nib_i(sr_q[WIDTH+4*g +: 4]), .nib_o(adj[4*g +: 4]));
  end
  assign shifted = {adj, sr_q[WIDTH-1:0]} << 1;
  assign last = (cnt_q == CW'(WIDTH - 1));
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      bcd_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      bcd_q <= bcd_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? SHIFT : IDLE;
      SHIFT:   state_d = last ? DONE : SHIFT;
      default: state_d = IDLE;
    endcase
  end
  // The result register only updates on the final shift so the display never shows partial digits
  always_comb begin
    sr_d = sr_q;
    cnt_d = cnt_q;
    bcd_d = bcd_q;
    if (state_q == IDLE && start) begin
      sr_d = {{BW{1'b0}}, bin_in};
      cnt_d = '0;
    end else if (state_q == SHIFT) begin
      sr_d = shifted;
      cnt_d = cnt_q + 1'b1;
      bcd_d = last ? shifted[SW-1 -: BW] : bcd_q;
    end
  end
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
    bcd_out = bcd_q;
  end
endmodule

// File: tb/tb_bcd_display_prep.sv
// tb_bcd_display_prep: directed and exhaustive checks of the BCD converter
module tb_bcd_display_prep;
  logic Clock = 1'b0;
  logic Reset_b;
  logic start;
  logic [7:0] bin_in;
  logic busy, done;
  logic [11:0] bcd_out;
  int tests = 0;
  int fails = 0;
  bcd_display_prep dut (
    .Clock(Clock), .Reset_b(Reset_b), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out)
  );
  always #5 Clock = ~Clock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [11:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  task automatic run_full(input logic [7:0] v, input logic [11:0] exp, input logic [11:0] prev);
    @(negedge Clock); start = 1'b1; bin_in = v;
    @(negedge Clock); start = 1'b0; bin_in = ~v;
    for (int i = 0; i < 8; i++) begin
      check("busy_shift", busy, 1);
      check("done_shift", done, 0);
      check("bcd_hold", bcd_out, prev);
      if (i < 7) @(negedge Clock);
    end
    @(negedge Clock);
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 0);
    check("bcd_result", bcd_out, exp);
    @(negedge Clock);
    check("done_end", done, 0);
    check("busy_end", busy, 0);
    check("bcd_kept", bcd_out, exp);
  endtask
  initial begin
    int pulses, last_done, cyc;
    Reset_b = 1'b0; start = 1'b0; bin_in = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd_out, 0);
    @(negedge Clock); @(negedge Clock);
    Reset_b = 1'b1;
    run_full(8'hFF, 12'h255, 12'h000);
    run_full(8'h00, 12'h000, 12'h255);
    run_full(8'h9C, 12'h156, 12'h000);
    run_full(8'h63, 12'h099, 12'h156);
    // start and bin_in changes during SHIFT must be ignored
    @(negedge Clock); start = 1'b1; bin_in = 8'h2A;
    @(negedge Clock); start = 1'b0;
    @(negedge Clock);
    @(negedge Clock); start = 1'b1; bin_in = 8'hFF;
    @(negedge Clock); start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        pulses++;
        check("ignore_bcd", bcd_out, 12'h042);
      end
      @(negedge Clock);
    end
    check("ignore_pulses", pulses, 1);
    check("ignore_idle", busy, 0);
    run_full(8'h80, 12'h128, 12'h042);
    @(negedge Clock); start = 1'b1; bin_in = 8'h07;
    @(negedge Clock); start = 1'b0;
    @(negedge Clock); @(negedge Clock); @(negedge Clock);
    #2 Reset_b = 1'b0;
    #1;
    check("abort_bcd", bcd_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge Clock);
    Reset_b = 1'b1;
    run_full(8'h07, 12'h007, 12'h000);
    @(negedge Clock); start = 1'b1; bin_in = 8'hC8;
    pulses = 0; last_done = -1; cyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (busy && done) check("busy_done_excl", {busy, done}, 2'b00);
      if (done) begin
        pulses++;
        check("cont_bcd", bcd_out, 12'h200);
        if (last_done >= 0) check("cont_period", cyc - last_done, 10);
        last_done = cyc;
      end
      cyc++;
    end
    check("cont_pulses", pulses, 3);
    start = 1'b0;
    for (int i = 0; i < 12; i++) @(negedge Clock);
    check("cont_idle", {busy, done}, 2'b00);
    for (int v = 0; v < 256; v++) begin
      @(negedge Clock); start = 1'b1; bin_in = 8'(v);
      @(negedge Clock); start = 1'b0;
      for (int i = 0; i < 8; i++) @(negedge Clock);
      check("sweep_done", done, 1);
      check("sweep_bcd", bcd_out, ref_bcd(v));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
